// File: rtl/ext_cpu_data_arbiter.sv
// Shares one OBI data port among NHARTS harts: round-robin arbitration, request hold and in-order response routing.
// Optional build macro EXT_CPU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
package ext_cpu_obi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module ext_cpu_data_arbiter
  import ext_cpu_obi_pkg::*;
#(
  parameter int NHARTS = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int IDW = $clog2(NHARTS),
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  obi_req_t        hart_req_i [NHARTS],
  output obi_resp_t       hart_resp_o [NHARTS],
  output obi_req_t        bus_req_o,
  input  obi_resp_t       bus_resp_i,
  output logic [OCW-1:0]  outstanding_o,
  output logic            protocol_err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Handshake: a request transfers on the cycle bus_req_o.req && bus_resp_i.gnt; only the hart
  // whose fields drive the bus sees gnt. rvalid has no back-pressure and always pops the ID FIFO.
  typedef enum logic {IDLE, HOLD} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] id_mem_q [MAX_OUTSTANDING];
  logic [IDW-1:0] id_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           full, any_req, req_ok, fire, pop;
  logic [IDW-1:0] winner, sel, head, rr_cur;
  obi_req_t       sel_req;

`ifndef EXT_CPU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_q, rr_d;
  assign rr_cur = rr_q;
`else
  assign rr_cur = '0;
`endif

  // Winner search starts at rr_cur and wraps modulo NHARTS (works for non-power-of-2 counts).
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    winner  = '0;
    for (int k = 0; k < NHARTS; k++) begin
      idx = int'(rr_cur) + k;
      if (idx >= NHARTS) idx = idx - NHARTS;
      if (!any_req && hart_req_i[idx].req) begin
        any_req = 1'b1;
        winner  = IDW'(idx);
      end
    end
  end

  // Next-state: selection, handshake, FIFO bookkeeping and FSM transitions.
  always_comb begin
    full    = (cnt_q == OCW'(MAX_OUTSTANDING));
    sel     = (state_q == HOLD) ? owner_q : winner;
    sel_req = '0;
    for (int i = 0; i < NHARTS; i++) begin
      if (sel == IDW'(i)) sel_req = hart_req_i[i];
    end
    req_ok  = sel_req.req && !full && rst_ni;
    fire    = req_ok && bus_resp_i.gnt;
    pop     = bus_resp_i.rvalid && (cnt_q != '0);
    head    = id_mem_q[rptr_q];

    state_d  = state_q;
    owner_d  = owner_q;
    id_mem_d = id_mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    err_d    = err_q | (bus_resp_i.rvalid && (cnt_q == '0));
    cnt_d    = cnt_q + OCW'(fire) - OCW'(pop);
`ifndef EXT_CPU_ARB_FIXED_PRIO_EN
    rr_d     = rr_q;
`endif

    case (state_q)
      IDLE: if (req_ok && !bus_resp_i.gnt) begin
        state_d = HOLD;
        owner_d = winner;
      end
      HOLD: if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fire) begin
      id_mem_d[wptr_q] = sel;
      wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PW'(1);
`ifndef EXT_CPU_ARB_FIXED_PRIO_EN
      rr_d = (sel == IDW'(NHARTS - 1)) ? '0 : sel + IDW'(1);
`endif
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PW'(1);
    end
  end

  // Outputs: bus request mux plus one-hot gnt / rvalid routing.
  always_comb begin
    bus_req_o     = sel_req;
    bus_req_o.req = req_ok;
    for (int i = 0; i < NHARTS; i++) begin
      hart_resp_o[i].gnt    = fire && (sel == IDW'(i));
      hart_resp_o[i].rvalid = pop && (head == IDW'(i));
      hart_resp_o[i].rdata  = (pop && (head == IDW'(i))) ? bus_resp_i.rdata : '0;
    end
    outstanding_o  = cnt_q;
    protocol_err_o = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_mem_q[i] <= '0;
`ifndef EXT_CPU_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      id_mem_q <= id_mem_d;
`ifndef EXT_CPU_ARB_FIXED_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ext_cpu_data_arbiter.sv
// Table-driven bench for ext_cpu_data_arbiter (NHARTS=2, MAX_OUTSTANDING=2), one vector per clock cycle.
module tb_ext_cpu_data_arbiter;
  import ext_cpu_obi_pkg::*;

`ifdef EXT_CPU_ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif
  localparam int EW = 141;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  obi_req_t   hart_req  [2];
  obi_resp_t  hart_resp [2];
  obi_req_t   bus_req;
  obi_resp_t  bus_resp;
  logic [1:0] outstanding;
  logic       protocol_err;

  ext_cpu_data_arbiter #(.NHARTS(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .hart_req_i    (hart_req),
    .hart_resp_o   (hart_resp),
    .bus_req_o     (bus_req),
    .bus_resp_i    (bus_resp),
    .outstanding_o (outstanding),
    .protocol_err_o(protocol_err)
  );

  // One cycle of stimulus and the outputs required before the next rising edge.
  typedef struct {
    string    nm;
    bit       rst;
    bit [1:0] req;
    bit       gnt;
    bit       rv;
    bit       ebreq;
    bit       esel;
    bit       eg;
    bit       erv;
    bit       ersel;
    bit [1:0] eout;
    bit       eerr;
  } vec_t;

  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(string nm, bit rst, bit [1:0] req, bit gnt, bit rv,
                              bit ebreq, bit esel, bit eg, bit erv, bit ersel,
                              bit [1:0] eout, bit eerr);
    vec_t v;
    v.nm = nm; v.rst = rst; v.req = req; v.gnt = gnt; v.rv = rv;
    v.ebreq = ebreq; v.esel = esel; v.eg = eg; v.erv = erv; v.ersel = ersel;
    v.eout = eout; v.eerr = eerr;
    return v;
  endfunction

  function automatic logic [69:0] pack_bus(obi_req_t r);
    return {r.req, r.req ? {r.addr, r.we, r.be, r.wdata} : 69'h0};
  endfunction

  function automatic logic [EW-1:0] actual_word();
    return {pack_bus(bus_req), hart_resp[1].gnt, hart_resp[0].gnt,
            hart_resp[1].rvalid, hart_resp[0].rvalid,
            hart_resp[0].rdata, hart_resp[1].rdata, outstanding, protocol_err};
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic apply(vec_t v);
    logic [EW-1:0] e, a;
    logic [31:0]   rd;
    logic [1:0]    g, r;
    obi_req_t      s;
    @(negedge clk);
    rst_ni = v.rst;
    for (int h = 0; h < 2; h++) begin
      hart_req[h].req   = v.req[h];
      hart_req[h].addr  = $urandom;
      hart_req[h].we    = 1'($urandom_range(0, 1));
      hart_req[h].be    = 4'($urandom_range(0, 15));
      hart_req[h].wdata = $urandom;
    end
    rd = $urandom;
    bus_resp.gnt    = v.gnt;
    bus_resp.rvalid = v.rv;
    bus_resp.rdata  = rd;
    s     = hart_req[v.esel];
    s.req = v.ebreq;
    g = v.eg  ? (v.esel  ? 2'b10 : 2'b01) : 2'b00;
    r = v.erv ? (v.ersel ? 2'b10 : 2'b01) : 2'b00;
    exp_q.push_back({pack_bus(s), g, r,
                     (v.erv && !v.ersel) ? rd : 32'h0,
                     (v.erv &&  v.ersel) ? rd : 32'h0,
                     v.eout, v.eerr});
    #3;
    a = actual_word();
    e = exp_q.pop_front();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h required %h", v.nm, a, e);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int h = 0; h < 2; h++) hart_req[h] = '0;
    bus_resp = '0;

    // reset state, with requests and bus activity present during reset
    vecs.push_back(mk("reset_a",  0, 2'b11, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk("reset_b",  0, 2'b11, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    // both harts request; gnt immediate, rvalid one cycle later
    vecs.push_back(mk("rr_c1",    1, 2'b11, 1, 0, 1, 0,   1, 0, 0,   2'd0, 0));
    vecs.push_back(mk("rr_c2",    1, 2'b11, 1, 1, 1, !FX, 1, 1, 0,   2'd1, 0));
    vecs.push_back(mk("rr_c3",    1, 2'b11, 1, 1, 1, 0,   1, 1, !FX, 2'd1, 0));
    vecs.push_back(mk("rr_c4",    1, 2'b11, 1, 1, 1, !FX, 1, 1, 0,   2'd1, 0));
    vecs.push_back(mk("rr_c5",    1, 2'b00, 1, 1, 0, 0,   0, 1, !FX, 2'd1, 0));
    vecs.push_back(mk("rr_c6",    1, 2'b11, 1, 0, 1, 0,   1, 0, 0,   2'd0, 0));
    vecs.push_back(mk("rr_c7",    1, 2'b00, 0, 1, 0, 0,   0, 1, 0,   2'd1, 0));
    vecs.push_back(mk("rr_c8",    1, 2'b11, 1, 0, 1, !FX, 1, 0, 0,   2'd0, 0));
    vecs.push_back(mk("rr_c9",    1, 2'b00, 0, 1, 0, 0,   0, 1, !FX, 2'd1, 0));
    // hold: hart0 owns the bus for 3 gnt-less cycles although the pointer favours hart1
    vecs.push_back(mk("hold_pre", 1, 2'b01, 1, 0, 1, 0,   1, 0, 0,   2'd0, 0));
    vecs.push_back(mk("hold_prv", 1, 2'b00, 0, 1, 0, 0,   0, 1, 0,   2'd1, 0));
    vecs.push_back(mk("hold_1",   1, 2'b01, 0, 0, 1, 0,   0, 0, 0,   2'd0, 0));
    vecs.push_back(mk("hold_2",   1, 2'b11, 0, 0, 1, 0,   0, 0, 0,   2'd0, 0));
    vecs.push_back(mk("hold_3",   1, 2'b11, 0, 0, 1, 0,   0, 0, 0,   2'd0, 0));
    vecs.push_back(mk("hold_gnt", 1, 2'b11, 1, 0, 1, 0,   1, 0, 0,   2'd0, 0));
    vecs.push_back(mk("hold_nxt", 1, 2'b11, 1, 0, 1, !FX, 1, 0, 0,   2'd1, 0));
    // FIFO full: no request on the bus, pop with full still blocks grant that cycle
    vecs.push_back(mk("full_1",   1, 2'b11, 1, 0, 0, 0,   0, 0, 0,   2'd2, 0));
    vecs.push_back(mk("full_2",   1, 2'b11, 1, 0, 0, 0,   0, 0, 0,   2'd2, 0));
    vecs.push_back(mk("full_pop", 1, 2'b11, 1, 1, 0, 0,   0, 1, 0,   2'd2, 0));
    vecs.push_back(mk("full_gnt", 1, 2'b11, 1, 0, 1, 0,   1, 0, 0,   2'd1, 0));
    // gnt and rvalid in the same cycle: old ID answered, new ID queued behind it
    vecs.push_back(mk("pp_pop",   1, 2'b00, 0, 1, 0, 0,   0, 1, !FX, 2'd2, 0));
    vecs.push_back(mk("pp_both",  1, 2'b11, 1, 1, 1, !FX, 1, 1, 0,   2'd1, 0));
    vecs.push_back(mk("pp_tail",  1, 2'b00, 0, 1, 0, 0,   0, 1, !FX, 2'd1, 0));
    // rvalid with empty FIFO
    vecs.push_back(mk("err_rv",   1, 2'b00, 0, 1, 0, 0,   0, 0, 0,   2'd0, 0));
    vecs.push_back(mk("err_set",  1, 2'b00, 0, 0, 0, 0,   0, 0, 0,   2'd0, 1));
    vecs.push_back(mk("err_gnt",  1, 2'b01, 1, 0, 1, 0,   1, 0, 0,   2'd0, 1));
    vecs.push_back(mk("err_rv0",  1, 2'b00, 0, 1, 0, 0,   0, 1, 0,   2'd1, 1));
    // pointer wrap: only hart0 with pointer at 1, then only hart1
    vecs.push_back(mk("wrap_0",   1, 2'b01, 1, 0, 1, 0,   1, 0, 0,   2'd0, 1));
    vecs.push_back(mk("wrap_0rv", 1, 2'b00, 0, 1, 0, 0,   0, 1, 0,   2'd1, 1));
    vecs.push_back(mk("only_1",   1, 2'b10, 1, 0, 1, 1,   1, 0, 0,   2'd0, 1));
    vecs.push_back(mk("only_1rv", 1, 2'b00, 0, 1, 0, 0,   0, 1, 1,   2'd1, 1));

    foreach (vecs[i]) apply(vecs[i]);

    // error flag stays set across idle cycles
    for (int i = 0; i < 3; i++) apply(mk("err_held", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));

    // reset asserted mid-cycle while in HOLD with one transaction outstanding
    apply(mk("rst_pre",   1, 2'b11, 1, 0, 1, 0,   1, 0, 0, 2'd0, 1));
    apply(mk("rst_hold",  1, 2'b11, 0, 0, 1, !FX, 0, 0, 0, 2'd1, 1));
    apply(mk("rst_async", 0, 2'b11, 1, 1, 0, 0,   0, 0, 0, 2'd0, 0));
    apply(mk("rst_late",  1, 2'b00, 0, 1, 0, 0,   0, 0, 0, 2'd0, 0));
    apply(mk("rst_h0",    1, 2'b11, 1, 0, 1, 0,   1, 0, 0, 2'd0, 1));
    apply(mk("rst_h0rv",  1, 2'b00, 0, 1, 0, 0,   0, 1, 0, 2'd1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
